if_stage: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register. It sits directly upstream of the ID-stage decoder/control and produces IF_ID_inst, IF_ID_pc and IF_ID_valid. The stage owns the PC and runs a single-outstanding-request handshake to instruction memory. It also applies decoder flush/redirect and hazard-unit stall to the IF/ID register.

---
 rtl/if_stage_if.sv | 19 +
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave): one request outstanding at a time.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, single-outstanding imem handshake,
// flush/redirect and stall handling. Optional counters via IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        IF_flush,
  input  logic [31:0] branch_target,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic        load_en;
  logic [31:0] load_data;
  logic        unused_bt;

  function automatic logic [31:0] align_pc(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

  assign unused_bt = ^branch_target[1:0];

  assign imem.imem_req  = (state == S_FETCH) && !rst;
  assign imem.imem_addr = pc;

  // IF/ID loads either straight from the response or from the hold buffer once stall clears
  assign load_en   = !IF_flush && !stall &&
                     ((state == S_WAIT && imem.imem_rvalid) || state == S_HOLD);
  assign load_data = (state == S_HOLD) ? hold_inst : imem.imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      IF_ID_inst  <= NOP_INST;
      IF_ID_pc    <= 32'h0;
      IF_ID_valid <= 1'b0;
    end else if (IF_flush) begin
      IF_ID_inst  <= NOP_INST;
      IF_ID_pc    <= 32'h0;
      IF_ID_valid <= 1'b0;
      pc          <= align_pc(branch_target[31:2]);
      case (state)
        S_FETCH: if (imem.imem_ready) state <= S_KILL;
        S_WAIT:  state <= imem.imem_rvalid ? S_FETCH : S_KILL;
        S_HOLD:  state <= S_FETCH;
        S_KILL:  if (imem.imem_rvalid) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end else begin
      if (load_en) begin
        IF_ID_inst  <= load_data;
        IF_ID_pc    <= pc;
        IF_ID_valid <= 1'b1;
        pc          <= pc + 32'd4;
      end
      case (state)
        S_FETCH: if (imem.imem_ready) state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              hold_inst <= imem.imem_rdata;
              state     <= S_HOLD;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_HOLD:  if (!stall) state <= S_FETCH;
        S_KILL:  if (imem.imem_rvalid) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (load_en)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (IF_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// transaction-level fetch model and a latency-randomized instruction memory.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, IF_flush;
  logic [31:0] branch_target;
  logic [31:0] IF_ID_inst, IF_ID_pc;
  logic        IF_ID_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
  logic [31:0] m_fcnt, m_flcnt;
`endif

  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
`ifdef IF_STAGE_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .clk(clk), .rst(rst), .imem(bus), .stall(stall), .IF_flush(IF_flush),
    .branch_target(branch_target), .IF_ID_inst(IF_ID_inst), .IF_ID_pc(IF_ID_pc),
    .IF_ID_valid(IF_ID_valid)
  );

  int n_chk = 0, n_pass = 0;

  // reference model: fetch pc, one outstanding request (possibly squashed),
  // one buffered instruction, and the IF/ID contents
  bit          m_known = 0;
  logic [31:0] m_pc, m_inst, m_ipc, m_buf;
  bit          m_valid, m_out, m_squash, m_buf_v;

  // instruction memory model
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, spur_pct = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_all();
    logic exp_req;
    exp_req = !rst && !m_out && !m_buf_v;
    chk("req", bus.imem_req, exp_req);
    if (exp_req) chk("addr", bus.imem_addr, m_pc);
    chk("if_id_inst", IF_ID_inst, m_inst);
    chk("if_id_pc", IF_ID_pc, m_ipc);
    chk("if_id_valid", IF_ID_valid, m_valid);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fcnt);
    chk("perf_flush", perf_flush_cnt, m_flcnt);
`endif
  endtask

  task automatic model_step(input bit r, s, f, input logic [31:0] bt,
                            input bit acc, rv, input logic [31:0] rd);
    bit          resp, have;
    logic [31:0] d;
    if (r) begin
      m_known = 1; m_pc = 32'h0; m_out = 0; m_squash = 0; m_buf_v = 0;
      m_inst = NOP; m_ipc = 32'h0; m_valid = 0;
`ifdef IF_STAGE_PERF_CNT_EN
      m_fcnt = 0; m_flcnt = 0;
`endif
      return;
    end
    resp = m_out && rv;
    have = 0;
    d    = 32'h0;
    if (f) begin
`ifdef IF_STAGE_PERF_CNT_EN
      m_flcnt++;
`endif
      m_inst = NOP; m_valid = 0; m_ipc = 32'h0;
      m_pc = {bt[31:2], 2'b00};
      m_buf_v = 0;
      if (resp) begin m_out = 0; m_squash = 0; end
      else if (m_out) m_squash = 1;
      if (acc) begin m_out = 1; m_squash = 1; end
    end else begin
      if (resp) begin
        m_out = 0;
        if (m_squash) m_squash = 0;
        else if (s) begin m_buf = rd; m_buf_v = 1; end
        else begin have = 1; d = rd; end
      end else if (m_buf_v && !s) begin
        have = 1; d = m_buf; m_buf_v = 0;
      end
      if (have) begin
        m_inst = d; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
`ifdef IF_STAGE_PERF_CNT_EN
        m_fcnt++;
`endif
      end
      if (acc) m_out = 1;
    end
  endtask

  // one clock: check outputs mid-cycle, then drive inputs for the next edge
  task automatic cycle(input bit r, s, f, input logic [31:0] bt);
    bit          fire, rv, rdy, acc, mreq;
    logic [31:0] rd;
    @(negedge clk);
    if (m_known) compare_all();
    rst = r; stall = s; IF_flush = f; branch_target = bt;
    fire = mem_pend && (mem_cnt == 0);
    rv   = fire;
    rd   = fire ? (ovr_en ? ovr_data : data_of(mem_addr)) : $urandom;
    if (!fire && !mem_pend && !m_out && ($urandom_range(99) < spur_pct)) rv = 1;
    rdy  = ($urandom_range(99) < ready_pct);
    bus.imem_ready = rdy; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    mreq = !r && !m_out && !m_buf_v;
    acc  = mreq && rdy;
    if (fire) begin mem_pend = 0; ovr_en = 0; end
    else if (mem_pend) mem_cnt--;
    if (acc) begin
      mem_pend = 1; mem_addr = m_pc;
      mem_cnt = $urandom_range(lat_max, lat_min) - 1;
    end
    if (r) mem_pend = 0;
    model_step(r, s, f, bt, acc, rv, rd);
  endtask

  task automatic step(input bit r, s, f, input logic [31:0] bt);
    cycle(r, s, f, bt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; IF_flush = 0; branch_target = 32'h0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 32'h0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_inst", IF_ID_inst, NOP);
    chk("rst_valid", IF_ID_valid, 1'b0);
    chk("rst_pc", IF_ID_pc, 32'h0);
    chk("rst_req", bus.imem_req, 1'b0);

    // zero-wait streaming: request, wait, load
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      #1;
      chk("t1_req", bus.imem_req, 1'b1);
      chk("t1_addr", bus.imem_addr, 32'(4 * i));
      @(posedge clk); #1;
      chk("t1_wait_req", bus.imem_req, 1'b0);
      step(0, 0, 0, 0);
      chk("t1_pc", IF_ID_pc, 32'(4 * i));
      chk("t1_valid", IF_ID_valid, 1'b1);
      chk("t1_inst", IF_ID_inst, data_of(32'(4 * i)));
    end

    // stall while the response arrives
    ovr_en = 1; ovr_data = 32'h00A0_0093;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t2_hold_pc", IF_ID_pc, 32'h8);
    chk("t2_hold_inst", IF_ID_inst, data_of(32'h8));
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t2_hold_req", bus.imem_req, 1'b0);
    chk("t2_hold_pc2", IF_ID_pc, 32'h8);
    step(0, 0, 0, 0);
    chk("t2_inst", IF_ID_inst, 32'h00A0_0093);
    chk("t2_pc", IF_ID_pc, 32'hC);
    chk("t2_valid", IF_ID_valid, 1'b1);

    // flush in WAIT before the response
    lat_min = 2; lat_max = 2;
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0103);
    chk("t3_inst", IF_ID_inst, NOP);
    chk("t3_valid", IF_ID_valid, 1'b0);
    chk("t3_kill_req", bus.imem_req, 1'b0);
    step(0, 0, 0, 0);
    chk("t3_after_valid", IF_ID_valid, 1'b0);
    chk("t3_req", bus.imem_req, 1'b1);
    chk("t3_addr", bus.imem_addr, 32'h0000_0100);

    // flush + stall together in HOLD
    lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0200);
    chk("t4_inst", IF_ID_inst, NOP);
    chk("t4_valid", IF_ID_valid, 1'b0);
    chk("t4_req", bus.imem_req, 1'b1);
    chk("t4_addr", bus.imem_addr, 32'h0000_0200);
    step(0, 1, 0, 0);
    chk("t4_accept_req", bus.imem_req, 1'b0);

    // pc wrap at the top of the address space
    step(0, 0, 0, 0);
    chk("t5_pre_pc", IF_ID_pc, 32'h0000_0200);
    ready_pct = 0;
    step(0, 0, 1, 32'hFFFF_FFFF);
    chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t5_req", bus.imem_req, 1'b1);
    ready_pct = 100;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_pc", IF_ID_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_addr", bus.imem_addr, 32'h0);

    // reset coinciding with a response in WAIT
    step(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #1;
    chk("t6_req_in_rst", bus.imem_req, 1'b0);
    @(posedge clk); #1;
    chk("t6_inst", IF_ID_inst, NOP);
    chk("t6_valid", IF_ID_valid, 1'b0);
    chk("t6_addr", bus.imem_addr, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("t6_fetch_cnt", perf_fetch_cnt, 32'h0);
    chk("t6_flush_cnt", perf_flush_cnt, 32'h0);
`endif

    // randomized traffic
    lat_min = 1; lat_max = 4; ready_pct = 60; spur_pct = 15;
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(199) == 0), ($urandom_range(99) < 30),
            ($urandom_range(99) < 10), $urandom);
    end
    cycle(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
